// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode: a DEPTH-entry circular buffer of
// {pc, instruction, misaligned}. It is emptied by a flush on a redirect.
module fetch_queue #(
  parameter int DEPTH     = 4,
  parameter int PTR_WIDTH = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [31:0]          in_pc,
  input  logic [31:0]          in_instruction,
  output logic                 in_ready,
  input  logic                 flush,
  output logic                 out_valid,
  output logic [31:0]          out_pc,
  output logic [31:0]          out_instruction,
  output logic                 out_misaligned,
  input  logic                 out_ready,
  output logic [PTR_WIDTH:0]   count
);

  localparam logic [PTR_WIDTH:0]   FULL_CNT = (PTR_WIDTH + 1)'(DEPTH);
  localparam logic [PTR_WIDTH:0]   CNT_ONE  = (PTR_WIDTH + 1)'(1);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);

  logic [PTR_WIDTH-1:0] wptr_q, wptr_d;
  logic [PTR_WIDTH-1:0] rptr_q, rptr_d;
  logic [PTR_WIDTH:0]   cnt_q, cnt_d;

  logic [31:0] pc_mem_q   [DEPTH];
  logic [31:0] pc_mem_d   [DEPTH];
  logic [31:0] inst_mem_q [DEPTH];
  logic [31:0] inst_mem_d [DEPTH];
  logic        mis_mem_q  [DEPTH];
  logic        mis_mem_d  [DEPTH];

  logic push;
  logic pop;

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high and flush is low. in_ready depends on registered occupancy only, so a
  // full queue never accepts in the same cycle that decode pops.
  assign in_ready  = (cnt_q != FULL_CNT);
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign count     = cnt_q;

  // Head is read straight from storage; zeroed while empty so stale data never leaks.
  assign out_pc          = out_valid ? pc_mem_q[rptr_q]   : 32'h0;
  assign out_instruction = out_valid ? inst_mem_q[rptr_q] : 32'h0;
  assign out_misaligned  = out_valid ? mis_mem_q[rptr_q]  : 1'b0;

  always_comb begin
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    mis_mem_d  = mis_mem_q;
    if (push) begin
      pc_mem_d[wptr_q]   = in_pc;
      inst_mem_d[wptr_q] = in_instruction;
      mis_mem_d[wptr_q]  = (in_pc[1:0] != 2'b00);
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_ONE;
      if (pop)  rptr_d = rptr_q + PTR_ONE;
      if (push && !pop)      cnt_d = cnt_q + CNT_ONE;
      else if (pop && !push) cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: out_valid masks every entry that is not live.
  always_ff @(posedge clock) begin
    pc_mem_q   <= pc_mem_d;
    inst_mem_q <= inst_mem_d;
    mis_mem_q  <= mis_mem_d;
  end

endmodule
